serial_parity_gen: RTL and testbench



---
 rtl/serial_parity_gen.sv | 122 ++++++++++++
 tb/tb_serial_parity_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_gen.sv
// serial_parity_gen: bit-serial running-parity generator (Moore machine).
//
// One bit `x` is accepted per rising edge of `clk` while `en` is high; `z`
// carries the parity of all accepted 1s (inverted when ODD_MODE=1). With
// FRAME_LEN>0 the parity restarts every FRAME_LEN accepted bits and
// `frame_done` pulses for one cycle after the last bit of each frame.
//
// Optional feature, macro SPG_ONES_CNT_EN: adds output `ones_cnt`, a
// saturating count of accepted 1s in the current frame.
//
// Input handshake: there is no back-pressure. A bit is transferred on every
// rising edge where en=1 and clr=0; en acts as the "valid" of the serial
// stream and the block is always ready. clr on an edge discards that bit.
module serial_parity_gen #(
   parameter int ODD_MODE  = 0,
   parameter int FRAME_LEN = 0,
   parameter int CNT_W     = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   input  logic x,
   output logic z,
   output logic frame_done
`ifdef SPG_ONES_CNT_EN
   ,
   output logic [CNT_W-1:0] ones_cnt
`endif
);

   // Parity state: EVEN = no (or an even number of) accepted 1s.
   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } par_t;

   localparam logic ODD_BIT = (ODD_MODE != 0);
   localparam logic [CNT_W-1:0] LAST_IDX =
      (FRAME_LEN > 0) ? CNT_W'(FRAME_LEN - 1) : '0;

   par_t             par, par_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             fstart, fstart_n;
   logic             fdone_n;
   par_t             par_base;

`ifdef SPG_ONES_CNT_EN
   logic [CNT_W-1:0] ones_q, ones_n;
`endif

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par        <= EVEN;
         cnt        <= '0;
         fstart     <= 1'b0;
         frame_done <= 1'b0;
`ifdef SPG_ONES_CNT_EN
         ones_q     <= '0;
`endif
      end else begin
         par        <= par_n;
         cnt        <= cnt_n;
         fstart     <= fstart_n;
         frame_done <= fdone_n;
`ifdef SPG_ONES_CNT_EN
         ones_q     <= ones_n;
`endif
      end
   end

   // Next-state logic: clr beats data; an accepted bit folds into parity,
   // and the first bit of a new frame starts from EVEN.
   always_comb begin
      par_n    = par;
      cnt_n    = cnt;
      fstart_n = fstart;
      fdone_n  = 1'b0;
      par_base = fstart ? EVEN : par;
`ifdef SPG_ONES_CNT_EN
      ones_n   = ones_q;
`endif
      if (clr) begin
         par_n    = EVEN;
         cnt_n    = '0;
         fstart_n = 1'b0;
`ifdef SPG_ONES_CNT_EN
         ones_n   = '0;
`endif
      end else if (en) begin
         par_n    = par_t'(logic'(par_base) ^ x);
         fstart_n = 1'b0;
         if (FRAME_LEN > 0) begin
            if (cnt == LAST_IDX) begin
               cnt_n    = '0;
               fstart_n = 1'b1;
               fdone_n  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`ifdef SPG_ONES_CNT_EN
         // A new frame reloads from this bit; otherwise count up and stick
         // at all-ones.
         if (fstart) begin
            ones_n = {{(CNT_W-1){1'b0}}, x};
         end else if (x && (ones_q != {CNT_W{1'b1}})) begin
            ones_n = ones_q + 1'b1;
         end
`endif
      end
   end

   // Output comes straight from the state register; no path from x.
   assign z = logic'(par) ^ ODD_BIT;

`ifdef SPG_ONES_CNT_EN
   assign ones_cnt = ones_q;
`endif

endmodule

// File: tb/tb_serial_parity_gen.sv
// tb_serial_parity_gen: directed test of serial_parity_gen.
//
// Three instances share one stimulus stream:
//   u_a : ODD_MODE=0, FRAME_LEN=0 (free-running even-parity bit)
//   u_b : ODD_MODE=1, FRAME_LEN=0 (free-running odd-parity bit)
//   u_c : ODD_MODE=0, FRAME_LEN=4 (framed)
// The driver pushes the hand-computed response for each edge into exp_q;
// the monitor pops and compares 1 ns after every rising edge that has a
// pending expectation.
module tb_serial_parity_gen;

  localparam int W = 14; // {az, afd, bz, bfd, cz, cfd, ones[7:0]}

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;
  logic clr   = 1'b0;
  logic x     = 1'b0;

  logic a_z, a_fd, b_z, b_fd, c_z, c_fd;
`ifdef SPG_ONES_CNT_EN
  logic [7:0] a_ones, b_ones, c_ones;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  serial_parity_gen #(.ODD_MODE(0), .FRAME_LEN(0), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x),
    .z(a_z), .frame_done(a_fd)
`ifdef SPG_ONES_CNT_EN
    , .ones_cnt(a_ones)
`endif
  );

  serial_parity_gen #(.ODD_MODE(1), .FRAME_LEN(0), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x),
    .z(b_z), .frame_done(b_fd)
`ifdef SPG_ONES_CNT_EN
    , .ones_cnt(b_ones)
`endif
  );

  serial_parity_gen #(.ODD_MODE(0), .FRAME_LEN(4), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x),
    .z(c_z), .frame_done(c_fd)
`ifdef SPG_ONES_CNT_EN
    , .ones_cnt(c_ones)
`endif
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag, input logic [W-1:0] e);
    chk({tag, " a_z"},  {7'd0, a_z},  {7'd0, e[13]});
    chk({tag, " a_fd"}, {7'd0, a_fd}, {7'd0, e[12]});
    chk({tag, " b_z"},  {7'd0, b_z},  {7'd0, e[11]});
    chk({tag, " b_fd"}, {7'd0, b_fd}, {7'd0, e[10]});
    chk({tag, " c_z"},  {7'd0, c_z},  {7'd0, e[9]});
    chk({tag, " c_fd"}, {7'd0, c_fd}, {7'd0, e[8]});
`ifdef SPG_ONES_CNT_EN
    chk({tag, " c_ones"}, c_ones, e[7:0]);
`endif
  endtask

  int edge_no = 0;

  // Monitor: one pop per rising edge that has an expectation pending.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        edge_no++;
        compare_all($sformatf("edge%0d", edge_no), e);
      end
    end
  end

  // ---------------- driver ----------------
  // Drive one edge's inputs and queue the state expected after that edge.
  task automatic step(input logic e_i, input logic c_i, input logic x_i,
                      input logic az, input logic bz, input logic cz,
                      input logic cfd, input logic [7:0] ones);
    @(negedge clk);
    #2;
    en  = e_i;
    clr = c_i;
    x   = x_i;
    exp_q.push_back({az, 1'b0, bz, 1'b0, cz, cfd, ones});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset: outputs must take reset values with no clock edge yet.
    #1 rst_n = 1'b0;
    #2;
    compare_all("reset", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Free-run: x = 0,1,0,1,0,1,0,1; u_c frames every 4 bits.
    //       en  clr x    az   bz   cz   cfd  ones
    step(1, 0, 0,   0,   1,   0,   0,   8'd0);
    step(1, 0, 1,   1,   0,   1,   0,   8'd1);
    step(1, 0, 0,   1,   0,   1,   0,   8'd1);
    step(1, 0, 1,   0,   1,   0,   1,   8'd2);
    step(1, 0, 0,   0,   1,   0,   0,   8'd0);
    step(1, 0, 1,   1,   0,   1,   0,   8'd1);
    step(1, 0, 0,   1,   0,   1,   0,   8'd1);
    step(1, 0, 1,   0,   1,   0,   1,   8'd2);

    // Clear everything, then en gating: three disabled 1s, one enabled 1.
    step(1, 1, 1,   0,   1,   0,   0,   8'd0);
    step(0, 0, 1,   0,   1,   0,   0,   8'd0);
    step(0, 0, 1,   0,   1,   0,   0,   8'd0);
    step(0, 0, 1,   0,   1,   0,   0,   8'd0);
    step(1, 0, 1,   1,   0,   1,   0,   8'd1);

    // clr priority over en/x while par=ODD, then a 0 keeps parity even.
    step(1, 1, 1,   0,   1,   0,   0,   8'd0);
    step(1, 0, 0,   0,   1,   0,   0,   8'd0);

    // Framing on u_c: x = 1,1,1,0 | 1,0,0,0 after a clear.
    step(0, 1, 0,   0,   1,   0,   0,   8'd0);
    step(1, 0, 1,   1,   0,   1,   0,   8'd1);
    step(1, 0, 1,   0,   1,   0,   0,   8'd2);
    step(1, 0, 1,   1,   0,   1,   0,   8'd3);
    step(1, 0, 0,   1,   0,   1,   1,   8'd3);
    step(1, 0, 1,   0,   1,   1,   0,   8'd1);
    step(1, 0, 0,   0,   1,   1,   0,   8'd1);
    step(1, 0, 0,   0,   1,   1,   0,   8'd1);
    step(1, 0, 0,   0,   1,   1,   1,   8'd1);

    // Async reset mid-frame: two bits, then rst_n low between edges.
    step(0, 1, 0,   0,   1,   0,   0,   8'd0);
    step(1, 0, 1,   1,   0,   1,   0,   8'd1);
    step(1, 0, 0,   1,   0,   1,   0,   8'd1);
    @(negedge clk);
    #2;
    en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    compare_all("midrst", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Frame restarts at cnt=0: done must come after exactly 4 new bits.
    step(1, 0, 1,   1,   0,   1,   0,   8'd1);
    step(1, 0, 1,   0,   1,   0,   0,   8'd2);
    step(1, 0, 1,   1,   0,   1,   0,   8'd3);
    step(1, 0, 1,   0,   1,   0,   1,   8'd4);
    step(0, 0, 1,   0,   1,   0,   0,   8'd4);

    // Drain the scoreboard with a bounded wait.
    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
